// File: rtl/hazard_fwd_unit_pkg.sv
// Shared encodings and decode helpers for the hazard/forwarding unit.
package hazard_fwd_unit_pkg;

    localparam logic [6:0] OP_LUI   = 7'b0110111;
    localparam logic [6:0] OP_AUIPC = 7'b0010111;
    localparam logic [6:0] OP_JAL   = 7'b1101111;
    localparam logic [6:0] OP_R     = 7'b0110011;
    localparam logic [6:0] OP_S     = 7'b0100011;
    localparam logic [6:0] OP_B     = 7'b1100011;

    localparam logic [1:0] WB_SEL_MEM = 2'b00;

    localparam logic [1:0] FWD_RF  = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    localparam logic [1:0] HZ_RUN   = 2'b00;
    localparam logic [1:0] HZ_LU    = 2'b01;
    localparam logic [1:0] HZ_REDIR = 2'b10;

    function automatic logic uses_rs1(input logic [6:0] op);
        return !(op == OP_LUI || op == OP_AUIPC || op == OP_JAL);
    endfunction

    function automatic logic uses_rs2(input logic [6:0] op);
        return (op == OP_R || op == OP_S || op == OP_B);
    endfunction

    // A load sitting in MEM has no data yet, so it must fall through to WB.
    function automatic logic [1:0] fwd_sel(
        input logic [4:0] rs,
        input logic [4:0] rd_m,
        input logic       ld_m,
        input logic [4:0] rd_w
    );
        if (rd_m != 5'd0 && rs == rd_m && !ld_m)
            return FWD_MEM;
        else if (rd_w != 5'd0 && rs == rd_w)
            return FWD_WB;
        else
            return FWD_RF;
    endfunction

endpackage

// File: rtl/hazard_fwd_unit_sat_counter.sv
// Saturating event counter; holds at all-ones instead of wrapping.
module sat_counter #(
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             inc,
    output logic [CNT_W-1:0] cnt
);

    always_ff @(posedge clk) begin
        if (reset)
            cnt <= '0;
        else if (inc && !(&cnt))
            cnt <= cnt + 1'b1;
    end

endmodule

// File: rtl/hazard_fwd_unit.sv
// Load-use / redirect hazard control and EX operand forwarding selects,
// with MEM/WB destination shadows and saturating event counters.
module hazard_fwd_unit
    import hazard_fwd_unit_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int CNT_W = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [WIDTH-1:0] instruction_d,
    input  logic [WIDTH-1:0] instruction_ex,
    input  logic             RegW_en_ex,
    input  logic [1:0]       WB_sel_ex,
    input  logic             PC_sel_ex,
    output logic             stall_f,
    output logic             stall_d,
    output logic             flush_fd,
    output logic             flush,
    output logic [1:0]       fwd_a_sel,
    output logic [1:0]       fwd_b_sel,
    output logic [1:0]       hz_state,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt
);

    logic [6:0] op_d;
    logic [4:0] rs1_d;
    logic [4:0] rs2_d;
    logic [4:0] rd_ex;
    logic [4:0] rs1_ex;
    logic [4:0] rs2_ex;

    assign op_d   = instruction_d[6:0];
    assign rs1_d  = instruction_d[19:15];
    assign rs2_d  = instruction_d[24:20];
    assign rd_ex  = instruction_ex[11:7];
    assign rs1_ex = instruction_ex[19:15];
    assign rs2_ex = instruction_ex[24:20];

    logic unused_d_bits;
    assign unused_d_bits = &{1'b0, instruction_d[WIDTH-1:25],
                             instruction_d[14:7]};

    logic wr_ex;
    logic ld_ex;

    // Flushed ID/EX keeps stale control bits; a zero word marks the bubble.
    assign wr_ex = RegW_en_ex && (rd_ex != 5'd0) &&
                   (instruction_ex != '0);
    assign ld_ex = wr_ex && (WB_sel_ex == WB_SEL_MEM);

    logic [4:0] rd_m;
    logic       ld_m;
    logic [4:0] rd_w;

    always_ff @(posedge clk) begin
        if (reset) begin
            rd_m <= 5'd0;
            ld_m <= 1'b0;
            rd_w <= 5'd0;
        end else begin
            rd_m <= wr_ex ? rd_ex : 5'd0;
            ld_m <= ld_ex;
            rd_w <= rd_m;
        end
    end

    assign fwd_a_sel = fwd_sel(rs1_ex, rd_m, ld_m, rd_w);
    assign fwd_b_sel = fwd_sel(rs2_ex, rd_m, ld_m, rd_w);

    logic lu;
    logic redir;
    logic lu_act;

    assign lu = ld_ex &&
                ((uses_rs1(op_d) && rs1_d == rd_ex) ||
                 (uses_rs2(op_d) && rs2_d == rd_ex));

    assign redir  = PC_sel_ex;
    assign lu_act = lu && !redir;

    assign stall_f  = lu_act;
    assign stall_d  = lu_act;
    assign flush_fd = redir;
    assign flush    = redir || lu_act;

    logic [1:0] hz_next;

    always_comb begin
        hz_next = HZ_RUN;
        unique case (1'b1)
            redir:   hz_next = HZ_REDIR;
            lu_act:  hz_next = HZ_LU;
            default: hz_next = HZ_RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset)
            hz_state <= HZ_RUN;
        else
            hz_state <= hz_next;
    end

    sat_counter #(.CNT_W(CNT_W)) u_stall_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (lu_act),
        .cnt   (stall_cnt)
    );

    sat_counter #(.CNT_W(CNT_W)) u_flush_cnt (
        .clk   (clk),
        .reset (reset),
        .inc   (redir),
        .cnt   (flush_cnt)
    );

endmodule

// File: tb/tb_hazard_fwd_unit.sv
// Directed-vector bench for hazard_fwd_unit with a queued scoreboard
// and a negedge monitor.
module tb_hazard_fwd_unit;

    localparam logic [6:0] T_LUI  = 7'b0110111;
    localparam logic [6:0] T_R    = 7'b0110011;
    localparam logic [6:0] T_S    = 7'b0100011;
    localparam logic [6:0] T_I    = 7'b0010011;
    localparam logic [6:0] T_LOAD = 7'b0000011;

    localparam int K_STF = 0;
    localparam int K_STD = 1;
    localparam int K_FFD = 2;
    localparam int K_FL  = 3;
    localparam int K_FA  = 4;
    localparam int K_FB  = 5;
    localparam int K_HZ  = 6;
    localparam int K_SC  = 7;
    localparam int K_FC  = 8;
    localparam int K_FC4 = 9;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] instruction_d;
    logic [31:0] instruction_ex;
    logic        RegW_en_ex;
    logic [1:0]  WB_sel_ex;
    logic        PC_sel_ex;

    logic        stall_f, stall_d, flush_fd, flush;
    logic [1:0]  fwd_a_sel, fwd_b_sel, hz_state;
    logic [15:0] stall_cnt, flush_cnt;

    logic        stall_f4, stall_d4, flush_fd4, flush4;
    logic [1:0]  fwd_a_sel4, fwd_b_sel4, hz_state4;
    logic [3:0]  stall_cnt4, flush_cnt4;

    always #5 clk = ~clk;

    hazard_fwd_unit #(.WIDTH(32), .CNT_W(16)) dut (
        .clk            (clk),
        .reset          (reset),
        .instruction_d  (instruction_d),
        .instruction_ex (instruction_ex),
        .RegW_en_ex     (RegW_en_ex),
        .WB_sel_ex      (WB_sel_ex),
        .PC_sel_ex      (PC_sel_ex),
        .stall_f        (stall_f),
        .stall_d        (stall_d),
        .flush_fd       (flush_fd),
        .flush          (flush),
        .fwd_a_sel      (fwd_a_sel),
        .fwd_b_sel      (fwd_b_sel),
        .hz_state       (hz_state),
        .stall_cnt      (stall_cnt),
        .flush_cnt      (flush_cnt)
    );

    hazard_fwd_unit #(.WIDTH(32), .CNT_W(4)) dut4 (
        .clk            (clk),
        .reset          (reset),
        .instruction_d  (instruction_d),
        .instruction_ex (instruction_ex),
        .RegW_en_ex     (RegW_en_ex),
        .WB_sel_ex      (WB_sel_ex),
        .PC_sel_ex      (PC_sel_ex),
        .stall_f        (stall_f4),
        .stall_d        (stall_d4),
        .flush_fd       (flush_fd4),
        .flush          (flush4),
        .fwd_a_sel      (fwd_a_sel4),
        .fwd_b_sel      (fwd_b_sel4),
        .hz_state       (hz_state4),
        .stall_cnt      (stall_cnt4),
        .flush_cnt      (flush_cnt4)
    );

    typedef struct {
        int          kind;
        logic [15:0] exp;
        string       name;
    } exp_t;

    exp_t q[$];
    int   n_run  = 0;
    int   n_fail = 0;

    function automatic logic [15:0] actual(input int kind);
        case (kind)
            K_STF:   return {15'd0, stall_f};
            K_STD:   return {15'd0, stall_d};
            K_FFD:   return {15'd0, flush_fd};
            K_FL:    return {15'd0, flush};
            K_FA:    return {14'd0, fwd_a_sel};
            K_FB:    return {14'd0, fwd_b_sel};
            K_HZ:    return {14'd0, hz_state};
            K_SC:    return stall_cnt;
            K_FC:    return flush_cnt;
            default: return {12'd0, flush_cnt4};
        endcase
    endfunction

    always @(negedge clk) begin
        while (q.size() > 0) begin
            exp_t e;
            logic [15:0] a;
            e = q.pop_front();
            a = actual(e.kind);
            n_run++;
            if (a !== e.exp) begin
                n_fail++;
                $display("FAIL %s: got %0d want %0d", e.name, a, e.exp);
            end
        end
    end

    initial begin
        #50000;
        n_fail++;
        $display("FAIL timeout: wait expired");
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

    task automatic chk(input int kind, input logic [15:0] exp,
                       input string name);
        exp_t e;
        e.kind = kind;
        e.exp  = exp;
        e.name = name;
        q.push_back(e);
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic drive(input logic [31:0] ex, input logic [31:0] id,
                         input logic regw, input logic [1:0] wb,
                         input logic pc);
        instruction_ex = ex;
        instruction_d  = id;
        RegW_en_ex     = regw;
        WB_sel_ex      = wb;
        PC_sel_ex      = pc;
    endtask

    function automatic logic [31:0] add_i(input logic [4:0] rd,
                                          input logic [4:0] rs1,
                                          input logic [4:0] rs2);
        return {7'd0, rs2, rs1, 3'b000, rd, T_R};
    endfunction

    function automatic logic [31:0] lw_i(input logic [4:0] rd,
                                         input logic [4:0] rs1);
        return {12'd0, rs1, 3'b010, rd, T_LOAD};
    endfunction

    initial begin
        reset = 1'b1;
        drive($urandom, $urandom, 1'b1, 2'b00, 1'b1);
        step();
        drive($urandom, $urandom, 1'b1, 2'b00, 1'b1);
        step();

        reset = 1'b0;
        drive(32'd0, 32'd0, 1'b0, 2'b00, 1'b0);
        n_run++;
        if (stall_cnt !== 16'd0 || flush_cnt !== 16'd0 ||
            hz_state !== 2'b00) begin
            n_fail++;
            $display("FAIL rst_direct: sc=%0d fc=%0d hz=%0d",
                     stall_cnt, flush_cnt, hz_state);
        end
        chk(K_SC, 0, "rst_stall_cnt");
        chk(K_FC, 0, "rst_flush_cnt");
        chk(K_HZ, 0, "rst_hz_state");
        chk(K_FA, 0, "rst_fwd_a");
        chk(K_FB, 0, "rst_fwd_b");
        chk(K_STF, 0, "rst_stall_f");
        chk(K_FL, 0, "rst_flush");
        step();

        drive(add_i(5, 1, 2), 32'd0, 1'b1, 2'b01, 1'b0);
        chk(K_FA, 0, "alu_a_none");
        step();
        drive(add_i(6, 5, 5), 32'd0, 1'b1, 2'b01, 1'b0);
        chk(K_FA, 1, "alu_a_mem");
        chk(K_FB, 1, "alu_b_mem");
        step();
        drive(add_i(9, 6, 5), 32'd0, 1'b1, 2'b01, 1'b0);
        chk(K_FA, 1, "alu_a_mem2");
        chk(K_FB, 2, "alu_b_wb");
        step();
        drive(add_i(9, 9, 0), 32'd0, 1'b1, 2'b01, 1'b0);
        chk(K_FA, 1, "alu_a_mem3");
        chk(K_FB, 0, "alu_b_x0");
        step();
        drive(add_i(12, 9, 9), 32'd0, 1'b0, 2'b01, 1'b0);
        chk(K_FA, 1, "prio_a_mem");
        chk(K_FB, 1, "prio_b_mem");
        step();

        drive(lw_i(7, 2), add_i(8, 7, 1), 1'b1, 2'b00, 1'b0);
        chk(K_STF, 1, "lu_stall_f");
        chk(K_STD, 1, "lu_stall_d");
        chk(K_FL, 1, "lu_flush");
        chk(K_FFD, 0, "lu_flush_fd");
        chk(K_HZ, 0, "lu_hz_pre");
        chk(K_SC, 0, "lu_cnt_pre");
        chk(K_FA, 0, "lu_fwd_a");
        step();
        drive(32'd0, add_i(8, 7, 1), 1'b1, 2'b00, 1'b0);
        chk(K_STF, 0, "lu_bubble_stall");
        chk(K_FL, 0, "lu_bubble_flush");
        chk(K_HZ, 1, "lu_hz_bub");
        chk(K_SC, 1, "lu_stall_cnt");
        step();
        drive(add_i(8, 7, 1), 32'd0, 1'b1, 2'b01, 1'b0);
        chk(K_FA, 2, "lu_dep_fwd_a");
        chk(K_FB, 0, "lu_dep_fwd_b");
        chk(K_HZ, 0, "lu_hz_run");
        step();

        drive(32'd0, add_i(8, 0, 0), 1'b1, 2'b00, 1'b0);
        chk(K_STF, 0, "bubble_stale_stall");
        chk(K_FL, 0, "bubble_stale_flush");
        step();
        drive(lw_i(0, 1), add_i(3, 0, 0), 1'b1, 2'b00, 1'b0);
        chk(K_STF, 0, "lw_x0_stall");
        chk(K_FL, 0, "lw_x0_flush");
        chk(K_SC, 1, "lw_x0_cnt");
        step();

        drive(lw_i(7, 2), {12'd0, 5'd7, 3'b000, 5'd8, T_LUI},
              1'b1, 2'b00, 1'b0);
        chk(K_STF, 0, "lui_no_rs1");
        step();
        drive(lw_i(7, 2), {7'd0, 5'd7, 5'd1, 3'b000, 5'd8, T_I},
              1'b1, 2'b00, 1'b0);
        chk(K_STF, 0, "itype_no_rs2");
        step();
        drive(lw_i(7, 2), {7'd0, 5'd7, 5'd1, 3'b010, 5'd0, T_S},
              1'b1, 2'b00, 1'b0);
        chk(K_STF, 1, "store_rs2_stall");
        chk(K_FL, 1, "store_rs2_flush");
        step();
        drive(32'd0, 32'd0, 1'b0, 2'b00, 1'b0);
        chk(K_SC, 2, "store_stall_cnt");
        chk(K_HZ, 1, "store_hz");
        step();

        drive(lw_i(4, 1), 32'd0, 1'b1, 2'b00, 1'b0);
        step();
        drive(add_i(5, 4, 4), 32'd0, 1'b1, 2'b01, 1'b0);
        chk(K_FA, 0, "ld_mem_no_fwd_a");
        chk(K_FB, 0, "ld_mem_no_fwd_b");
        step();
        drive(add_i(6, 4, 5), 32'd0, 1'b1, 2'b01, 1'b0);
        chk(K_FA, 2, "ld_wb_fwd_a");
        chk(K_FB, 1, "ld_next_mem_b");
        step();

        drive(lw_i(7, 2), add_i(8, 7, 1), 1'b1, 2'b00, 1'b1);
        chk(K_FFD, 1, "redir_flush_fd");
        chk(K_FL, 1, "redir_flush");
        chk(K_STF, 0, "redir_stall_f");
        chk(K_STD, 0, "redir_stall_d");
        chk(K_FC, 0, "redir_fc_pre");
        step();
        drive(32'd0, 32'd0, 1'b0, 2'b00, 1'b0);
        chk(K_HZ, 2, "redir_hz");
        chk(K_FC, 1, "redir_flush_cnt");
        chk(K_SC, 2, "redir_stall_cnt");
        chk(K_FFD, 0, "redir_clear");
        step();

        reset = 1'b1;
        drive(32'd0, 32'd0, 1'b0, 2'b00, 1'b0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 20; i++) begin
            drive(32'd0, 32'd0, 1'b0, 2'b00, 1'b1);
            if (i == 0) begin
                chk(K_FC4, 0, "sat_start4");
                chk(K_FC, 0, "sat_start");
                chk(K_HZ, 0, "sat_hz_rst");
            end
            if (i == 16)
                chk(K_FC4, 15, "sat_hold16");
            step();
        end
        drive(32'd0, 32'd0, 1'b0, 2'b00, 1'b0);
        chk(K_FC4, 15, "sat_final4");
        chk(K_FC, 20, "sat_final16");
        chk(K_HZ, 2, "sat_hz");
        step();

        @(negedge clk);
        #1;
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
